// File: rtl/sm_position_ctrl.sv
// Stepper-motor position controller: tracks position from step edges and runs
// point-to-point moves with a direction setup delay, end-switch and step-timeout faults.
module sm_position_ctrl #(
  parameter int POS_W        = 32,
  parameter int DIR_SETUP    = 4,
  parameter int STEP_TIMEOUT = 1048576
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    drv_step,
  input  logic                    cmd_valid,
  input  logic signed [POS_W-1:0] cmd_target,
  input  logic                    cmd_abort,
  input  logic                    zero_set,
  input  logic                    fault_clr,
  input  logic                    limit_fwd,
  input  logic                    limit_rev,
  output logic                    drv_enable_SM,
  output logic                    drv_dir,
  output logic signed [POS_W-1:0] position,
  output logic                    busy,
  output logic                    done,
  output logic                    fault
);

  localparam int SET_W = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
  localparam int WD_W  = $clog2(STEP_TIMEOUT + 1);
  localparam logic [SET_W-1:0]        SET_LAST = SET_W'(DIR_SETUP - 1);
  localparam logic [WD_W-1:0]         WD_LAST  = WD_W'(STEP_TIMEOUT - 1);
  localparam logic signed [POS_W-1:0] POS_ONE  = POS_W'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN, FAULT} state_t;

  state_t                    state_reg, state_next;
  logic                      step_d_reg;
  logic signed [POS_W-1:0]   position_reg, position_next;
  logic signed [POS_W-1:0]   target_reg, target_next;
  logic                      dir_reg, dir_next;
  logic                      enable_reg;
  logic                      done_reg, done_next;
  logic [SET_W-1:0]          set_cnt_reg, set_cnt_next;
  logic [WD_W-1:0]           wd_reg, wd_next;
  logic                      step_edge;
  logic                      limit_hit;
  logic signed [POS_W-1:0]   pos_step;

  assign step_edge = drv_step & ~step_d_reg;
  assign pos_step  = dir_reg ? position_reg + POS_ONE : position_reg - POS_ONE;
  assign limit_hit = dir_reg ? limit_fwd : limit_rev;

  always_comb begin
    state_next    = state_reg;
    position_next = position_reg;
    target_next   = target_reg;
    dir_next      = dir_reg;
    done_next     = 1'b0;
    set_cnt_next  = set_cnt_reg;
    wd_next       = wd_reg;

    // Edges are counted in every state, including trailing edges after a stop.
    if (step_edge) position_next = pos_step;

    case (state_reg)
      IDLE: begin
        if (zero_set) position_next = '0;
        if (cmd_valid) begin
          if (cmd_target == position_reg) begin
            done_next = 1'b1;
          end else begin
            target_next  = cmd_target;
            dir_next     = (cmd_target > position_reg);
            set_cnt_next = '0;
            state_next   = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (limit_hit)                  state_next = FAULT;
        else if (cmd_abort)             state_next = IDLE;
        else if (set_cnt_reg == SET_LAST) begin
          state_next = RUN;
          wd_next    = '0;
        end else begin
          set_cnt_next = set_cnt_reg + 1'b1;
        end
      end
      RUN: begin
        wd_next = step_edge ? '0 : wd_reg + 1'b1;
        // Reaching the target outranks limit, timeout and abort in the same cycle.
        if (step_edge && pos_step == target_reg) begin
          state_next    = IDLE;
          position_next = target_reg;
          done_next     = 1'b1;
        end else if (limit_hit) begin
          state_next = FAULT;
        end else if (!step_edge && wd_reg == WD_LAST) begin
          state_next = FAULT;
        end else if (cmd_abort) begin
          state_next = IDLE;
        end
      end
      FAULT: begin
        if (fault_clr && !limit_fwd && !limit_rev) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      step_d_reg   <= 1'b0;
      position_reg <= '0;
      target_reg   <= '0;
      dir_reg      <= 1'b0;
      enable_reg   <= 1'b0;
      done_reg     <= 1'b0;
      set_cnt_reg  <= '0;
      wd_reg       <= '0;
    end else begin
      state_reg    <= state_next;
      step_d_reg   <= drv_step;
      position_reg <= position_next;
      target_reg   <= target_next;
      dir_reg      <= dir_next;
      enable_reg   <= (state_next == RUN);
      done_reg     <= done_next;
      set_cnt_reg  <= set_cnt_next;
      wd_reg       <= wd_next;
    end
  end

  assign drv_enable_SM = enable_reg;
  assign drv_dir       = dir_reg;
  assign position      = position_reg;
  assign busy          = (state_reg == SETTLE) || (state_reg == RUN);
  assign done          = done_reg;
  assign fault         = (state_reg == FAULT);

endmodule

// File: tb/tb_sm_position_ctrl.sv
// Directed bench for sm_position_ctrl: expected values queued at stimulus time,
// popped and compared against the DUT after the relevant clock edge.
module tb_sm_position_ctrl;

  localparam int POS_W = 32;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    drv_step = 1'b0;
  logic                    cmd_valid = 1'b0;
  logic signed [POS_W-1:0] cmd_target = '0;
  logic                    cmd_abort = 1'b0;
  logic                    zero_set = 1'b0;
  logic                    fault_clr = 1'b0;
  logic                    limit_fwd = 1'b0;
  logic                    limit_rev = 1'b0;
  logic                    drv_enable_SM;
  logic                    drv_dir;
  logic signed [POS_W-1:0] position;
  logic                    busy;
  logic                    done;
  logic                    fault;

  sm_position_ctrl #(
    .POS_W(POS_W),
    .DIR_SETUP(4),
    .STEP_TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .drv_step(drv_step),
    .cmd_valid(cmd_valid),
    .cmd_target(cmd_target),
    .cmd_abort(cmd_abort),
    .zero_set(zero_set),
    .fault_clr(fault_clr),
    .limit_fwd(limit_fwd),
    .limit_rev(limit_rev),
    .drv_enable_SM(drv_enable_SM),
    .drv_dir(drv_dir),
    .position(position),
    .busy(busy),
    .done(done),
    .fault(fault)
  );

  always #10 clk = ~clk;

  string       tag_q[$];
  logic [31:0] exp_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic push_exp(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic check(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp;
    n_assert++;
    if (tag_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: observed %0d, nothing expected", obs);
      return;
    end
    tag = tag_q.pop_front();
    exp = exp_q.pop_front();
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("txn %-22s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle step pulse followed by one low cycle.
  task automatic pulse();
    drv_step = 1'b1;
    tick();
    drv_step = 1'b0;
    tick();
  endtask

  task automatic issue(input int tgt);
    cmd_valid  = 1'b1;
    cmd_target = tgt;
    tick();
    cmd_valid  = 1'b0;
  endtask

  // Full move: command, settle, edges, target reach with a single done pulse.
  task automatic do_move(input int tgt, input int edges, input logic exp_dir);
    issue(tgt);
    push_exp("move_dir", 32'(exp_dir)); check(32'(drv_dir));
    repeat (4) tick();
    for (int i = 0; i < edges - 1; i++) pulse();
    drv_step = 1'b1;
    tick();
    drv_step = 1'b0;
    push_exp("move_pos", tgt);  check(position);
    push_exp("move_done", 1);   check(32'(done));
    push_exp("move_en_off", 0); check(32'(drv_enable_SM));
    tick();
    push_exp("move_done_once", 0); check(32'(done));
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    push_exp("rst_pos", 0);  check(position);
    push_exp("rst_en", 0);   check(32'(drv_enable_SM));
    push_exp("rst_dir", 0);  check(32'(drv_dir));
    push_exp("rst_busy", 0); check(32'(busy));
    push_exp("rst_done", 0); check(32'(done));
    push_exp("rst_fault", 0); check(32'(fault));

    // 0 -> 5 with detailed timing, plus a command ignored while busy
    issue(5);
    push_exp("fwd_dir_p1", 1);  check(32'(drv_dir));
    push_exp("fwd_busy_p1", 1); check(32'(busy));
    push_exp("fwd_en_p1", 0);   check(32'(drv_enable_SM));
    cmd_valid = 1'b1; cmd_target = -20;
    tick();
    cmd_valid = 1'b0;
    push_exp("busy_cmd_ignored", 1); check(32'(drv_dir));
    tick(); tick();
    push_exp("fwd_en_p4", 0); check(32'(drv_enable_SM));
    tick();
    push_exp("fwd_en_p5", 1); check(32'(drv_enable_SM));
    repeat (4) pulse();
    push_exp("fwd_pos4", 4);  check(position);
    push_exp("fwd_en_run", 1); check(32'(drv_enable_SM));
    push_exp("fwd_no_early_done", 0); check(32'(done));
    drv_step = 1'b1;
    tick();
    drv_step = 1'b0;
    push_exp("fwd_pos5", 5);   check(position);
    push_exp("fwd_en_off", 0); check(32'(drv_enable_SM));
    push_exp("fwd_done", 1);   check(32'(done));
    push_exp("fwd_idle", 0);   check(32'(busy));
    tick();
    push_exp("fwd_done_once", 0); check(32'(done));

    // 5 -> 10, then 10 -> 7 in reverse
    do_move(10, 5, 1'b1);
    do_move(7, 3, 1'b0);

    // zero_set beats a simultaneous step edge
    zero_set = 1'b1; drv_step = 1'b1;
    tick();
    zero_set = 1'b0; drv_step = 1'b0;
    push_exp("zero_beats_step", 0); check(position);
    tick();

    // Abort after 20 edges, one trailing edge counted, no done
    issue(100);
    repeat (4) tick();
    repeat (20) pulse();
    push_exp("abort_pos20", 20); check(position);
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    push_exp("abort_idle", 0);  check(32'(busy));
    push_exp("abort_en", 0);    check(32'(drv_enable_SM));
    push_exp("abort_no_done", 0); check(32'(done));
    pulse();
    push_exp("abort_trailing", 21); check(position);
    push_exp("abort_no_done2", 0);  check(32'(done));

    // Forward limit after 3 edges
    zero_set = 1'b1; tick(); zero_set = 1'b0;
    issue(50);
    repeat (4) tick();
    repeat (3) pulse();
    limit_fwd = 1'b1;
    tick();
    push_exp("limit_fault", 1); check(32'(fault));
    push_exp("limit_en", 0);    check(32'(drv_enable_SM));
    push_exp("limit_pos", 3);   check(position);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    push_exp("clr_with_limit", 1); check(32'(fault));
    issue(9);
    push_exp("fault_cmd_ignored", 0); check(32'(busy));
    limit_fwd = 1'b0; fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    push_exp("clr_fault", 0);   check(32'(fault));
    push_exp("clr_to_idle", 0); check(32'(busy));

    // Watchdog: no steps in RUN, fault after the 64th RUN cycle
    issue(10);
    repeat (4) tick();
    push_exp("wd_run_start", 1); check(32'(drv_enable_SM));
    repeat (63) tick();
    push_exp("wd_cycle64_run", 0); check(32'(fault));
    tick();
    push_exp("wd_fault", 1);   check(32'(fault));
    push_exp("wd_en_off", 0);  check(32'(drv_enable_SM));
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    push_exp("wd_cleared", 0); check(32'(fault));

    // Reset mid-RUN at position 42
    issue(100);
    repeat (4) tick();
    repeat (39) pulse();
    push_exp("pre_rst_pos", 42); check(position);
    push_exp("pre_rst_en", 1);   check(32'(drv_enable_SM));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_exp("rst_mid_pos", 0);  check(position);
    push_exp("rst_mid_en", 0);   check(32'(drv_enable_SM));
    push_exp("rst_mid_busy", 0); check(32'(busy));
    issue(0);
    push_exp("same_tgt_done", 1); check(32'(done));
    push_exp("same_tgt_idle", 0); check(32'(busy));
    tick();
    push_exp("same_tgt_once", 0); check(32'(done));
    push_exp("same_tgt_no_en", 0); check(32'(drv_enable_SM));

    if (tag_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: observed %0d entries, expected 0", tag_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
